// File: rtl/keypad_ctrl.sv
// keypad_ctrl: 4x4 matrix keypad scanner, whole-frame debouncer and player
// control for the Raiden game top.
//
// The scanner drives one keypad row low at a time, samples the synchronised
// column lines on the last cycle of each row dwell, and assembles a 16-bit
// frame snapshot. A snapshot must repeat for DEBOUNCE_SCANS consecutive frames
// before it is committed to keys. Press edges of the committed state move the
// player up/down (clamped to POS_MIN..POS_MAX) and raise fire_pulse.
// Optional auto-repeat steps the player while exactly one move key is held.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   keypadRow  out  row drive, active-low one-hot
//   keypadCol  in   column sense, active-low, asynchronous to clk
//   playerPos  out  player centre row, POS_MIN..POS_MAX
//   fire       out  debounced FIRE_KEY level
//   fire_pulse out  one-clk pulse on debounced FIRE_KEY press edge
//   keys       out  debounced key state, bit k = key 4*row+col pressed
module keypad_ctrl #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 40,
  parameter int POS_MIN        = 1,
  parameter int POS_MAX        = 6,
  parameter int POS_INIT       = 3,
  parameter int UP_KEY         = 1,
  parameter int DOWN_KEY       = 9,
  parameter int FIRE_KEY       = 5
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  keypadRow,
  input  logic [3:0]  keypadCol,
  output logic [2:0]  playerPos,
  output logic        fire,
  output logic        fire_pulse,
  output logic [15:0] keys
);

  localparam int                CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam int                STB_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [STB_W-1:0]  STB_TOP  = STB_W'(DEBOUNCE_SCANS);
  localparam int                REP_W    = (REPEAT_SCANS > 0) ? $clog2(REPEAT_SCANS + 1) : 1;
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'((REPEAT_SCANS > 0) ? (REPEAT_SCANS - 1) : 0);
  localparam logic [2:0]        P_MIN    = 3'(POS_MIN);
  localparam logic [2:0]        P_MAX    = 3'(POS_MAX);
  localparam logic [2:0]        P_INIT   = 3'(POS_INIT);

  typedef enum logic [1:0] {ROW0 = 2'd0, ROW1 = 2'd1, ROW2 = 2'd2, ROW3 = 2'd3} row_e;

  logic [3:0]       col_meta_q, col_sync_q;
  logic [CNT_W-1:0] cnt_q;
  row_e             row_q, row_next_s;
  logic [3:0]       row_drv_q, drv_next_s;
  logic [15:0]      snap_q, snap_new_s, frame_q;
  logic [STB_W-1:0] stable_q, stable_new_s;
  logic [15:0]      keys_q, keys_prev_q, press_s;
  logic             sample_s, frame_end_s, frame_tick_q, keys_chg_s, up_s, dn_s;
  logic [2:0]       pos_q, pos_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             fire_pulse_q;

  function automatic logic [2:0] pos_inc(input logic [2:0] p);
    return (p >= P_MAX) ? P_MAX : (p + 3'd1);
  endfunction

  function automatic logic [2:0] pos_dec(input logic [2:0] p);
    return (p <= P_MIN) ? P_MIN : (p - 3'd1);
  endfunction

  // Two-flop synchroniser for the asynchronous column lines (idle = pulled high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
    end else begin
      col_meta_q <= keypadCol;
      col_sync_q <= col_meta_q;
    end
  end

  // Snapshot merge, next row selection and debounce count for the sample cycle.
  always_comb begin
    snap_new_s = snap_q;
    row_next_s = ROW0;
    drv_next_s = 4'b1110;
    case (row_q)
      ROW0: begin snap_new_s[3:0]   = ~col_sync_q; row_next_s = ROW1; drv_next_s = 4'b1101; end
      ROW1: begin snap_new_s[7:4]   = ~col_sync_q; row_next_s = ROW2; drv_next_s = 4'b1011; end
      ROW2: begin snap_new_s[11:8]  = ~col_sync_q; row_next_s = ROW3; drv_next_s = 4'b0111; end
      ROW3: begin snap_new_s[15:12] = ~col_sync_q; row_next_s = ROW0; drv_next_s = 4'b1110; end
      default: begin snap_new_s = snap_q; row_next_s = ROW0; drv_next_s = 4'b1110; end
    endcase
    sample_s    = (cnt_q == CNT_LAST);
    frame_end_s = sample_s && (row_q == ROW3);
    if (snap_new_s == frame_q) begin
      stable_new_s = (stable_q == STB_TOP) ? stable_q : (stable_q + STB_W'(1));
    end else begin
      stable_new_s = STB_W'(1);
    end
  end

  // Scan FSM: row dwell, per-row sampling and frame-level debounce commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      row_q        <= ROW0;
      row_drv_q    <= 4'b1110;
      snap_q       <= 16'h0000;
      frame_q      <= 16'h0000;
      stable_q     <= '0;
      keys_q       <= 16'h0000;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= frame_end_s;
      if (sample_s) begin
        cnt_q     <= '0;
        row_q     <= row_next_s;
        row_drv_q <= drv_next_s;
        snap_q    <= snap_new_s;
        if (row_q == ROW3) begin
          frame_q  <= snap_new_s;
          stable_q <= stable_new_s;
          if (stable_new_s == STB_TOP) begin
            keys_q <= snap_new_s;
          end
        end
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Move and auto-repeat decision. keys only changes at a frame end, so press
  // edges and key changes are seen on the same cycle as frame_tick_q.
  always_comb begin
    press_s    = keys_q & ~keys_prev_q;
    keys_chg_s = (keys_q != keys_prev_q);
    up_s       = keys_q[UP_KEY];
    dn_s       = keys_q[DOWN_KEY];
    pos_d      = pos_q;
    rep_d      = rep_q;
    if (up_s && dn_s) begin
      rep_d = '0;
    end else if (press_s[UP_KEY]) begin
      pos_d = pos_inc(pos_q);
      rep_d = '0;
    end else if (press_s[DOWN_KEY]) begin
      pos_d = pos_dec(pos_q);
      rep_d = '0;
    end else if (keys_chg_s || !(up_s || dn_s) || (REPEAT_SCANS == 0)) begin
      rep_d = '0;
    end else if (frame_tick_q) begin
      if (rep_q == REP_LAST) begin
        rep_d = '0;
        pos_d = up_s ? pos_inc(pos_q) : pos_dec(pos_q);
      end else begin
        rep_d = rep_q + REP_W'(1);
      end
    end else begin
      rep_d = rep_q;
    end
  end

  // Player position, repeat count, edge-detect history and fire pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q        <= P_INIT;
      rep_q        <= '0;
      keys_prev_q  <= 16'h0000;
      fire_pulse_q <= 1'b0;
    end else begin
      pos_q        <= pos_d;
      rep_q        <= rep_d;
      keys_prev_q  <= keys_q;
      fire_pulse_q <= press_s[FIRE_KEY];
    end
  end

  assign keypadRow  = row_drv_q;
  assign playerPos  = pos_q;
  assign fire       = keys_q[FIRE_KEY];
  assign fire_pulse = fire_pulse_q;
  assign keys       = keys_q;

endmodule

// File: tb/tb_keypad_ctrl.sv
// tb_keypad_ctrl: directed test of keypad_ctrl with SCAN_DIV=4, DEBOUNCE_SCANS=2.
// dut_a uses REPEAT_SCANS=0, dut_b uses REPEAT_SCANS=3. A behavioural keypad
// pulls each instance's column lines low for pressed keys on the driven row.
// A frame is 16 clks; after reset release the frame ends on edges 16, 32, ...
module tb_keypad_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] press_a, press_b;
  logic [3:0]  row_a, row_b, col_a, col_b;
  logic [2:0]  pos_a, pos_b;
  logic        fire_a, fire_b, fp_a, fp_b;
  logic [15:0] keys_a, keys_b;
  int          total = 0;
  int          bad   = 0;
  int          fp_cnt_a = 0;
  int          base;

  function automatic logic [3:0] col_of(input logic [3:0] row, input logic [15:0] k);
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int cc = 0; cc < 4; cc++) begin
        if (!row[r] && k[4*r+cc]) c[cc] = 1'b0;
      end
    end
    return c;
  endfunction

  assign col_a = col_of(row_a, press_a);
  assign col_b = col_of(row_b, press_b);

  keypad_ctrl #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2), .REPEAT_SCANS(0)) dut_a (
    .clk(clk), .rst(rst), .keypadRow(row_a), .keypadCol(col_a), .playerPos(pos_a),
    .fire(fire_a), .fire_pulse(fp_a), .keys(keys_a));

  keypad_ctrl #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2), .REPEAT_SCANS(3)) dut_b (
    .clk(clk), .rst(rst), .keypadRow(row_b), .keypadCol(col_b), .playerPos(pos_b),
    .fire(fire_b), .fire_pulse(fp_b), .keys(keys_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count clocks on which dut_a's fire_pulse is high.
  always @(posedge clk) fp_cnt_a <= fp_cnt_a + (fp_a ? 1 : 0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Release for 2 frames (commit release), then press for 2 frames (commit press).
  task automatic tap(input bit on_b, input int key);
    if (on_b) press_b = 16'h0000; else press_a = 16'h0000;
    run(32);
    if (on_b) press_b[key] = 1'b1; else press_a[key] = 1'b1;
    run(32);
  endtask

  initial begin
    logic [3:0] er;
    int         ep;
    rst = 1'b0; press_a = 16'h0000; press_b = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_row", {28'd0, row_a}, 32'hE);
    chk("rst_pos", {29'd0, pos_a}, 32'd3);
    chk("rst_keys", {16'd0, keys_a}, 32'd0);
    chk("rst_fire", {31'd0, fire_a}, 32'd0);
    chk("rst_fp", {31'd0, fp_a}, 32'd0);
    chk("rst_pos_b", {29'd0, pos_b}, 32'd3);
    rst = 1'b1;

    // 1: idle scan for 3 frames
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      er = ~(4'b0001 << ((k / 4) % 4));
      chk("row_scan", {28'd0, row_a}, {28'd0, er});
    end
    chk("idle_pos", {29'd0, pos_a}, 32'd3);
    chk("idle_keys", {16'd0, keys_a}, 32'd0);
    chk("idle_fire", {31'd0, fire_a}, 32'd0);
    run(1);

    // 2: key 1 held 3 frames, then repeated taps up to the top
    press_a[1] = 1'b1;
    run(16);
    chk("up_deb1", {16'd0, keys_a}, 32'd0);
    run(16);
    chk("up_keys", {16'd0, keys_a}, 32'h0002);
    chk("up_pos4", {29'd0, pos_a}, 32'd4);
    run(16);
    chk("up_hold", {29'd0, pos_a}, 32'd4);
    tap(1'b0, 1);
    chk("up_pos5", {29'd0, pos_a}, 32'd5);
    tap(1'b0, 1);
    chk("up_pos6", {29'd0, pos_a}, 32'd6);
    tap(1'b0, 1);
    chk("up_sat", {29'd0, pos_a}, 32'd6);

    // 3: eight taps of key 9 from POS_INIT
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk); rst = 1'b1;
    run(1);
    chk("dn_start", {29'd0, pos_a}, 32'd3);
    for (int i = 0; i < 8; i++) begin
      tap(1'b0, 9);
      ep = (i == 0) ? 2 : 1;
      chk("dn_pos", {29'd0, pos_a}, ep);
    end

    // 4: bouncing fire key never commits, then a clean hold
    press_a = 16'h0000;
    run(32);
    chk("fire_idle", {16'd0, keys_a}, 32'd0);
    base = fp_cnt_a;
    for (int i = 0; i < 6; i++) begin
      press_a[5] = (i % 2 == 0);
      run(16);
      chk("bounce_keys", {16'd0, keys_a}, 32'd0);
    end
    chk("bounce_fp", fp_cnt_a - base, 32'd0);
    press_a[5] = 1'b1;
    base = fp_cnt_a;
    run(32);
    chk("fire_lvl", {31'd0, fire_a}, 32'd1);
    chk("fp_high", {31'd0, fp_a}, 32'd1);
    run(1);
    chk("fp_low", {31'd0, fp_a}, 32'd0);
    run(15);
    chk("fire_held", {31'd0, fire_a}, 32'd1);
    chk("fp_once", fp_cnt_a - base, 32'd1);

    // 5: auto-repeat on dut_b from position 1
    tap(1'b1, 9);
    chk("rep_pos2", {29'd0, pos_b}, 32'd2);
    tap(1'b1, 9);
    chk("rep_pos1", {29'd0, pos_b}, 32'd1);
    press_b = 16'h0000;
    run(32);
    chk("rep_rel", {16'd0, keys_b}, 32'd0);
    chk("rep_start", {29'd0, pos_b}, 32'd1);
    press_b[1] = 1'b1;
    for (int f = 1; f <= 18; f++) begin
      run(16);
      if (f < 2) ep = 1;
      else ep = (2 + (f - 2) / 3 > 6) ? 6 : 2 + (f - 2) / 3;
      chk("rep_pos", {29'd0, pos_b}, ep);
    end
    press_b[9] = 1'b1;
    run(32);
    chk("both_keys", {16'd0, keys_b}, 32'h0202);
    chk("both_pos", {29'd0, pos_b}, 32'd6);
    run(96);
    chk("both_hold", {29'd0, pos_b}, 32'd6);

    // 6: asynchronous reset mid row 2 with key 5 held on dut_a
    run(9);
    chk("pre_row2", {28'd0, row_a}, 32'hB);
    chk("pre_fire", {31'd0, fire_a}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar_row", {28'd0, row_a}, 32'hE);
    chk("ar_fire", {31'd0, fire_a}, 32'd0);
    chk("ar_keys", {16'd0, keys_a}, 32'd0);
    chk("ar_pos", {29'd0, pos_a}, 32'd3);
    chk("ar_pos_b", {29'd0, pos_b}, 32'd3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run(1);
    chk("rr_fire0", {31'd0, fire_a}, 32'd0);
    run(30);
    chk("rr_fire31", {31'd0, fire_a}, 32'd0);
    run(1);
    chk("rr_fire32", {31'd0, fire_a}, 32'd1);
    chk("rr_fp32", {31'd0, fp_a}, 32'd0);
    base = fp_cnt_a;
    run(1);
    chk("rr_fp33", {31'd0, fp_a}, 32'd1);
    run(1);
    chk("rr_fp34", {31'd0, fp_a}, 32'd0);
    run(32);
    chk("rr_fp_once", fp_cnt_a - base, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
